instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Multi-cycle control FSM that steps one instruction at a time through fetch, decode, execute, memory and writeback. It drives the instruction/data memory handshakes, the IR latch, PC update select, register-file write enable and a retired-instruction counter. The immediate generator and ALU stay combinational. This block decides when their results are consumed, using the cuOPType op code from the decoder.

Parameters:
MAX_WAIT, 15, max cycles spent waiting for iready/dready before error
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
nRst  in  1  asynchronous active-low reset
enable  in  1  run request; sampled in IDLE and at instruction end
iready  in  1  instruction memory ack; instr valid when high
dready  in  1  data memory ack
cuOp  in  6  cuOPType from decoder, valid from DECODE onward
branchTaken  in  1  branch compare result, valid in EXEC
iread  out  1  instruction fetch request
dread  out  1  data load request
dwrite  out  1  data store request
irEn  out  1  latch instr into IR
pcEn  out  1  PC register load enable
pcSel  out  2  next-PC source (PC_INC, PC_BRANCH, PC_JAL, PC_JALR)
regWrite  out  1  register file write enable
retired  out  1  one-cycle pulse per completed instruction
retireCnt  out  CNT_W  count of retired instructions
error  out  1  sticky fault flag
state  out  3  current state, for debug

Behaviour:
- Reset (async, nRst=0): state=IDLE; retireCnt=0; wait counter=0; all other outputs 0. Takes effect mid-operation; any in-flight request drops immediately.
- Outputs are decoded combinationally from state and inputs. Default for all outputs is 0. pcSel defaults to PC_INC.
- IDLE: if enable, go to FETCH.
- FETCH: iread=1.
  - When iready=1: irEn=1 in that same cycle, then DECODE.
- DECODE: 1 cycle.
  - cuOp==CU_ERROR: go to ERROR.
  - Otherwise: go to EXEC.
- EXEC: 1 cycle, action by op class.
  - Load/store (CU_LB..CU_SW): go to MEM.
  - Branch (CU_BEQ..CU_BGEU): pcEn=1; pcSel=PC_BRANCH if branchTaken, else PC_INC; retire.
  - CU_JAL: regWrite=1, pcEn=1, pcSel=PC_JAL; retire.
  - CU_JALR: regWrite=1, pcEn=1, pcSel=PC_JALR; retire.
  - All other ops (ALU, LUI, AUIPC): go to WB.
- MEM: dread=1 for loads, dwrite=1 for stores, held until dready.
  - On dready=1 with a load: go to WB.
  - On dready=1 with a store: pcEn=1, pcSel=PC_INC; retire.
- WB: regWrite=1, pcEn=1, pcSel=PC_INC; retire.
- Retire means:
  - retired=1 for that cycle; retireCnt increments on the following edge and wraps at 2^CNT_W-1 to 0.
  - Next state is FETCH if enable=1, else IDLE.
- enable deasserting mid-instruction does not abort; the instruction completes, then the FSM goes to IDLE.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle in FETCH/MEM while ready is low.
  - Reaching MAX_WAIT with ready low sends the FSM to ERROR.
  - If ready is high in the same cycle the count equals MAX_WAIT, ready wins.
- ERROR: error=1 and all requests 0. Terminal; only nRst exits.
- Cycle counts with zero-wait memory: ALU op 4 cycles, load 5, store 4, branch/jump 3.

Decomposition:
- Shared package cu_pkg holds:
  - cuOPType (moved out of the sign extender file so all consumers share one definition).
  - seqState enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERROR.
  - pcSel constants: PC_INC=0, PC_BRANCH=1, PC_JAL=2, PC_JALR=3.
  - opClass enum: OC_ALU, OC_UPPER, OC_LOAD, OC_STORE, OC_BRANCH, OC_JAL, OC_JALR, OC_ERR.
- One sub-module, op_classifier: combinational map from cuOp to opClass, reused by the sign extender and hazard logic later.

Test Plan:
- Reset then enable=1, cuOp=CU_ADDI, iready high on 3rd FETCH cycle -> irEn exactly once, then DECODE/EXEC/WB; regWrite and pcEn in WB; retired pulse; retireCnt=1.
- cuOp=CU_LW, iready and dready immediate -> dread=1 one cycle in MEM; regWrite in WB; 5 cycles total; store CU_SW -> dwrite, no regWrite, retire from MEM.
- CU_BEQ with branchTaken=1 then CU_BNE with branchTaken=0 -> pcSel=1 then 0 in EXEC; pcEn=1; regWrite=0; retireCnt=2.
- CU_JALR -> in EXEC regWrite=1, pcSel=3, retire, back to FETCH.
- iready held low, MAX_WAIT=15 -> ERROR after 15 wait cycles, error=1 sticky; iready=1 exactly at count 15 -> no error, normal completion.
- nRst pulsed low during MEM with dread=1 -> dread drops at once; state=IDLE; retireCnt=0. enable dropped in EXEC of an ALU op -> completes WB, then IDLE.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared control-unit types: decoder op codes, sequencer states,
// next-PC select codes and the op classes used by the sequencer.
package cu_pkg;

    // Decoder op code. Loads, stores and branches are kept contiguous.
    typedef enum logic [5:0] {
        CU_LUI   = 6'd0,
        CU_AUIPC = 6'd1,
        CU_JAL   = 6'd2,
        CU_JALR  = 6'd3,
        CU_BEQ   = 6'd4,
        CU_BNE   = 6'd5,
        CU_BLT   = 6'd6,
        CU_BGE   = 6'd7,
        CU_BLTU  = 6'd8,
        CU_BGEU  = 6'd9,
        CU_LB    = 6'd10,
        CU_LH    = 6'd11,
        CU_LW    = 6'd12,
        CU_LBU   = 6'd13,
        CU_LHU   = 6'd14,
        CU_SB    = 6'd15,
        CU_SH    = 6'd16,
        CU_SW    = 6'd17,
        CU_ADDI  = 6'd18,
        CU_SLTI  = 6'd19,
        CU_SLTIU = 6'd20,
        CU_XORI  = 6'd21,
        CU_ORI   = 6'd22,
        CU_ANDI  = 6'd23,
        CU_SLLI  = 6'd24,
        CU_SRLI  = 6'd25,
        CU_SRAI  = 6'd26,
        CU_ADD   = 6'd27,
        CU_SUB   = 6'd28,
        CU_SLL   = 6'd29,
        CU_SLT   = 6'd30,
        CU_SLTU  = 6'd31,
        CU_XOR   = 6'd32,
        CU_SRL   = 6'd33,
        CU_SRA   = 6'd34,
        CU_OR    = 6'd35,
        CU_AND   = 6'd36,
        CU_ERROR = 6'd63
    } cuOPType;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERROR  = 3'd6
    } seqState;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JAL    = 2'd2;
    localparam logic [1:0] PC_JALR   = 2'd3;

    typedef enum logic [2:0] {
        OC_ALU    = 3'd0,
        OC_UPPER  = 3'd1,
        OC_LOAD   = 3'd2,
        OC_STORE  = 3'd3,
        OC_BRANCH = 3'd4,
        OC_JAL    = 3'd5,
        OC_JALR   = 3'd6,
        OC_ERR    = 3'd7
    } opClass;

endpackage

// File: rtl/op_classifier.sv
// Combinational mapping from decoder op code to the coarse op class that
// control logic (sequencer, sign extender, hazard logic) acts on.
module op_classifier
    import cu_pkg::*;
(
    input  cuOPType cuOp,
    output opClass  op_class
);

    // Anything not listed explicitly is a register/immediate ALU op.
    always_comb begin
        op_class = OC_ALU;
        case (cuOp)
            CU_LUI, CU_AUIPC:                       op_class = OC_UPPER;
            CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU:    op_class = OC_LOAD;
            CU_SB, CU_SH, CU_SW:                    op_class = OC_STORE;
            CU_BEQ, CU_BNE, CU_BLT, CU_BGE,
            CU_BLTU, CU_BGEU:                       op_class = OC_BRANCH;
            CU_JAL:                                 op_class = OC_JAL;
            CU_JALR:                                op_class = OC_JALR;
            CU_ERROR:                               op_class = OC_ERR;
            default:                                op_class = OC_ALU;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Drives memory handshakes, IR latch, PC update and register write, counts
// retired instructions and traps to a terminal ERROR state on a bad op code
// or a memory that fails to answer within MAX_WAIT cycles.
module instr_sequencer
    import cu_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             enable,
    input  logic             iready,
    input  logic             dready,
    input  cuOPType          cuOp,
    input  logic             branchTaken,
    output logic             iread,
    output logic             dread,
    output logic             dwrite,
    output logic             irEn,
    output logic             pcEn,
    output logic [1:0]       pcSel,
    output logic             regWrite,
    output logic             retired,
    output logic [CNT_W-1:0] retireCnt,
    output logic             error,
    output logic [2:0]       state
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    seqState           cur_state;
    seqState           nxt_state;
    opClass            op_class;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_expired;
    logic              retire;

    op_classifier u_op_classifier (
        .cuOp     (cuOp),
        .op_class (op_class)
    );

    assign state        = cur_state;
    assign retired      = retire;
    assign wait_expired = (wait_cnt == WAIT_LIMIT);

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) cur_state <= IDLE;
        else       cur_state <= nxt_state;
    end

    // Next-state and output decode; ready beats an expiring wait count.
    always_comb begin
        nxt_state = cur_state;
        iread     = 1'b0;
        dread     = 1'b0;
        dwrite    = 1'b0;
        irEn      = 1'b0;
        pcEn      = 1'b0;
        pcSel     = PC_INC;
        regWrite  = 1'b0;
        retire    = 1'b0;
        error     = 1'b0;
        case (cur_state)
            IDLE: begin
                if (enable) nxt_state = FETCH;
            end
            FETCH: begin
                iread = 1'b1;
                if (iready) begin
                    irEn      = 1'b1;
                    nxt_state = DECODE;
                end else if (wait_expired) begin
                    nxt_state = ERROR;
                end
            end
            DECODE: begin
                nxt_state = (op_class == OC_ERR) ? ERROR : EXEC;
            end
            EXEC: begin
                case (op_class)
                    OC_LOAD, OC_STORE: nxt_state = MEM;
                    OC_BRANCH: begin
                        pcEn   = 1'b1;
                        pcSel  = branchTaken ? PC_BRANCH : PC_INC;
                        retire = 1'b1;
                    end
                    OC_JAL: begin
                        regWrite = 1'b1;
                        pcEn     = 1'b1;
                        pcSel    = PC_JAL;
                        retire   = 1'b1;
                    end
                    OC_JALR: begin
                        regWrite = 1'b1;
                        pcEn     = 1'b1;
                        pcSel    = PC_JALR;
                        retire   = 1'b1;
                    end
                    default: nxt_state = WB;
                endcase
            end
            MEM: begin
                if (op_class == OC_LOAD) dread  = 1'b1;
                else                     dwrite = 1'b1;
                if (dready) begin
                    if (op_class == OC_LOAD) begin
                        nxt_state = WB;
                    end else begin
                        pcEn   = 1'b1;
                        retire = 1'b1;
                    end
                end else if (wait_expired) begin
                    nxt_state = ERROR;
                end
            end
            WB: begin
                regWrite = 1'b1;
                pcEn     = 1'b1;
                retire   = 1'b1;
            end
            ERROR: begin
                error = 1'b1;
            end
            default: nxt_state = IDLE;
        endcase
        if (retire) nxt_state = enable ? FETCH : IDLE;
    end

    // Memory wait counter: restarts on entry to FETCH/MEM, counts stalled cycles.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wait_cnt <= '0;
        end else if ((nxt_state == FETCH && cur_state != FETCH) ||
                     (nxt_state == MEM   && cur_state != MEM)) begin
            wait_cnt <= '0;
        end else if (((cur_state == FETCH && !iready) ||
                      (cur_state == MEM   && !dready)) && !wait_expired) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)       retireCnt <= '0;
        else if (retire) retireCnt <= retireCnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-instruction scoreboard of
// retire-cycle outputs plus cycle/strobe counts and fault scenarios.
module tb_instr_sequencer;
    import cu_pkg::*;

    logic        clk;
    logic        nRst;
    logic        enable;
    logic        iready;
    logic        dready;
    cuOPType     cuOp;
    logic        branchTaken;
    logic        iread;
    logic        dread;
    logic        dwrite;
    logic        irEn;
    logic        pcEn;
    logic [1:0]  pcSel;
    logic        regWrite;
    logic        retired;
    logic [31:0] retireCnt;
    logic        error;
    logic [2:0]  state;

    typedef struct {
        logic        rw;
        logic [1:0]  sel;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;
    int   n_retired;

    instr_sequencer #(.MAX_WAIT(15), .CNT_W(32)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .enable      (enable),
        .iready      (iready),
        .dready      (dready),
        .cuOp        (cuOp),
        .branchTaken (branchTaken),
        .iread       (iread),
        .dread       (dread),
        .dwrite      (dwrite),
        .irEn        (irEn),
        .pcEn        (pcEn),
        .pcSel       (pcSel),
        .regWrite    (regWrite),
        .retired     (retired),
        .retireCnt   (retireCnt),
        .error       (error),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH; memory answers after iwait/dwait stall cycles.
    task automatic run_instr(input string name, input cuOPType op, input logic br,
                             input int iwait, input int dwait, input bit drop,
                             input int exp_cycles, input int exp_rw, input int exp_rd,
                             input int exp_wr, input logic [1:0] exp_sel);
        exp_t e;
        exp_t got;
        int   cycles, fcnt, mcnt, n_ir, n_rw, n_rd, n_wr;
        bit   done;
        e.rw  = (exp_rw != 0);
        e.sel = exp_sel;
        e.cnt = 32'(n_retired);
        sb_q.push_back(e);
        n_retired++;
        cycles = 0; fcnt = 0; mcnt = 0; n_ir = 0; n_rw = 0; n_rd = 0; n_wr = 0;
        done = 1'b0;
        cuOp = op;
        branchTaken = br;
        check_eq({name, "_start"}, 32'(state), 32'(FETCH));
        for (int g = 0; g < 200 && !done; g++) begin
            iready = (state == FETCH) && (fcnt >= iwait);
            if (state == FETCH) fcnt++;
            dready = (state == MEM) && (mcnt >= dwait);
            if (state == MEM) mcnt++;
            if (drop && state == EXEC) enable = 1'b0;
            #1;
            cycles++;
            if (irEn)     n_ir++;
            if (regWrite) n_rw++;
            if (dread)    n_rd++;
            if (dwrite)   n_wr++;
            if (retired) begin
                done = 1'b1;
                if (sb_q.size() == 0) begin
                    check_eq({name, "_sb_underflow"}, 32'(1), 32'(0));
                end else begin
                    got = sb_q.pop_front();
                    check_eq({name, "_regWrite"}, 32'(regWrite), 32'(got.rw));
                    check_eq({name, "_pcSel"}, 32'(pcSel), 32'(got.sel));
                    check_eq({name, "_pcEn"}, 32'(pcEn), 32'(1));
                    check_eq({name, "_retireCnt"}, retireCnt, got.cnt);
                end
            end
            step();
        end
        iready = 1'b0;
        dready = 1'b0;
        if (!done) check_eq({name, "_timeout"}, 32'(0), 32'(1));
        check_eq({name, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        check_eq({name, "_irEn"}, 32'(n_ir), 32'(1));
        check_eq({name, "_rw_cnt"}, 32'(n_rw), 32'(exp_rw));
        check_eq({name, "_dread_cnt"}, 32'(n_rd), 32'(exp_rd));
        check_eq({name, "_dwrite_cnt"}, 32'(n_wr), 32'(exp_wr));
        check_eq({name, "_next"}, 32'(state), enable ? 32'(FETCH) : 32'(IDLE));
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        step();
        step();
        nRst = 1'b1;
        n_retired = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        n_checks = 0; n_fail = 0; n_retired = 0;
        nRst = 1'b0; enable = 1'b0; iready = 1'b0; dready = 1'b0;
        cuOp = CU_ADDI; branchTaken = 1'b0;
        #3;
        check_eq("rst_state", 32'(state), 32'(IDLE));
        check_eq("rst_cnt", retireCnt, 32'(0));
        check_eq("rst_iread", 32'(iread), 32'(0));
        check_eq("rst_pcSel", 32'(pcSel), 32'(0));
        check_eq("rst_error", 32'(error), 32'(0));
        step();
        nRst = 1'b1;
        step();
        check_eq("idle_hold", 32'(state), 32'(IDLE));
        enable = 1'b1;
        step();

        // name, op, br, iwait, dwait, drop, cycles, rw, rd, wr, sel
        run_instr("addi",   CU_ADDI, 1'b0,  2,  0, 1'b0,  6, 1,  0,  0, PC_INC);
        run_instr("lw",     CU_LW,   1'b0,  0,  0, 1'b0,  5, 1,  1,  0, PC_INC);
        run_instr("sw",     CU_SW,   1'b0,  0,  0, 1'b0,  4, 0,  0,  1, PC_INC);
        run_instr("beq",    CU_BEQ,  1'b1,  0,  0, 1'b0,  3, 0,  0,  0, PC_BRANCH);
        run_instr("bne",    CU_BNE,  1'b0,  0,  0, 1'b0,  3, 0,  0,  0, PC_INC);
        run_instr("jal",    CU_JAL,  1'b0,  0,  0, 1'b0,  3, 1,  0,  0, PC_JAL);
        run_instr("jalr",   CU_JALR, 1'b0,  0,  0, 1'b0,  3, 1,  0,  0, PC_JALR);
        run_instr("lui",    CU_LUI,  1'b0,  0,  0, 1'b0,  4, 1,  0,  0, PC_INC);
        run_instr("lw_w3",  CU_LW,   1'b0,  0,  3, 1'b0,  8, 1,  4,  0, PC_INC);
        run_instr("add_i15", CU_ADD, 1'b0, 15,  0, 1'b0, 19, 1,  0,  0, PC_INC);
        run_instr("sw_d15", CU_SW,   1'b0,  0, 15, 1'b0, 19, 0,  0, 16, PC_INC);
        run_instr("xor_drop", CU_XOR, 1'b0, 0,  0, 1'b1,  4, 1,  0,  0, PC_INC);

        // Reset in the middle of a load's MEM phase.
        enable = 1'b1;
        step();
        check_eq("restart_fetch", 32'(state), 32'(FETCH));
        cuOp = CU_LW;
        cyc = 0;
        for (int g = 0; g < 50 && cyc < 3; g++) begin
            iready = (state == FETCH);
            dready = 1'b0;
            if (state == MEM) cyc++;
            if (cyc < 3) step();
        end
        iready = 1'b0;
        #1;
        check_eq("mem_dread", 32'(dread), 32'(1));
        check_eq("mem_cnt_before", retireCnt, 32'(n_retired));
        nRst = 1'b0;
        #1;
        check_eq("rstmid_dread", 32'(dread), 32'(0));
        check_eq("rstmid_state", 32'(state), 32'(IDLE));
        check_eq("rstmid_cnt", retireCnt, 32'(0));
        check_eq("rstmid_iread", 32'(iread), 32'(0));
        step();
        nRst = 1'b1;
        n_retired = 0;
        step();
        check_eq("post_rst_fetch", 32'(state), 32'(FETCH));
        run_instr("andi_post", CU_ANDI, 1'b0, 0, 0, 1'b0, 4, 1, 0, 0, PC_INC);

        // Bad op code traps in DECODE.
        cuOp = CU_ERROR;
        iready = 1'b1;
        #1;
        check_eq("err_irEn", 32'(irEn), 32'(1));
        step();
        iready = 1'b0;
        check_eq("err_decode", 32'(state), 32'(DECODE));
        step();
        check_eq("err_state", 32'(state), 32'(ERROR));
        check_eq("err_flag", 32'(error), 32'(1));
        check_eq("err_retired", 32'(retired), 32'(0));

        // Instruction memory never answers.
        do_reset();
        cuOp = CU_ADDI;
        step();
        check_eq("to_fetch", 32'(state), 32'(FETCH));
        cyc = 0;
        for (int g = 0; g < 100 && state == FETCH; g++) begin
            cyc++;
            step();
        end
        check_eq("to_fetch_cycles", 32'(cyc), 32'(16));
        check_eq("to_state", 32'(state), 32'(ERROR));
        iready = 1'b1;
        dready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            step();
            check_eq("sticky_error", 32'(error), 32'(1));
            check_eq("sticky_iread", 32'(iread), 32'(0));
            check_eq("sticky_state", 32'(state), 32'(ERROR));
        end
        check_eq("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
